sliced_subtractor: RTL

- Multi-cycle 32-bit subtractor; the inverse operation to the datapath's 32-bit ripple adder. Computes diff = a - b - bin.
- Processes one SLICE-bit chunk per clock, LSB first, and propagates the borrow between chunks.
- Uses a start/busy/done handshake so the multi-cycle ALU path can share one narrow slice subtractor instead of a full-width one.

---
 rtl/sliced_subtractor_pkg.sv | 20 ++
 rtl/sliced_subtractor_slice.sv | 19 +
 rtl/sliced_subtractor.sv | 112 +++++++++++
 3 files changed

// File: rtl/sliced_subtractor_pkg.sv
// Shared types and default sizing for the sliced subtractor.
package sliced_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_SLICE  = 8;
  localparam int DEF_NSLICE = DEF_WIDTH / DEF_SLICE;
  localparam int DEF_CNT_W  = $clog2(DEF_NSLICE);

  // Slice counter width; a single-slice build still needs one bit.
  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/sliced_subtractor_slice.sv
// Combinational SLICE-bit borrow subtractor: {bout, diff} = a - b - bin.
module slice_subtractor #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] diff,
  output logic             bout
);

  logic [SLICE:0] res;

  // The extra MSB turns negative results into a borrow flag.
  assign res  = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
  assign diff = res[SLICE-1:0];
  assign bout = res[SLICE];

endmodule

// File: rtl/sliced_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one SLICE-bit chunk per clock, LSB first.
// Optional signed-overflow output enabled by SLICED_SUBTRACTOR_OVF_EN.
module sliced_subtractor
  import sliced_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SLICED_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = cnt_width(NSLICE);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow;
  logic [SLICE-1:0] sa;
  logic [SLICE-1:0] sb;
  logic [SLICE-1:0] sd;
  logic             sbo;
  logic             last;
  logic             accept;

  always_comb begin
    sa = a_q[int'(cnt)*SLICE +: SLICE];
    sb = b_q[int'(cnt)*SLICE +: SLICE];
  end

  assign last   = (cnt == CNT_W'(NSLICE - 1));
  // A new request is only taken when no operation is in flight.
  assign accept = start && (state != RUN);

  slice_subtractor #(
    .SLICE (SLICE)
  ) u_slice (
    .a    (sa),
    .b    (sb),
    .bin  (borrow),
    .diff (sd),
    .bout (sbo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      borrow <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SLICED_SUBTRACTOR_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_q    <= a;
      b_q    <= b;
      borrow <= bin;
      cnt    <= '0;
      busy   <= 1'b1;
      done   <= 1'b0;
      state  <= RUN;
    end else begin
      case (state)
        RUN: begin
          diff[int'(cnt)*SLICE +: SLICE] <= sd;
          borrow <= sbo;
          if (last) begin
            cnt   <= '0;
            bout  <= sbo;
`ifdef SLICED_SUBTRACTOR_OVF_EN
            // sd[SLICE-1] is the result MSB on the final slice.
            ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sd[SLICE-1] != a_q[WIDTH-1]);
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
